mul_acc: RTL
============

Name: mul_acc

Overview:
- Sequential unsigned shift-and-add multiply-accumulate unit. Computes P = A*B + C over WIDTH clock iterations.
- It is the inverse of the calculator's restoring divider. Feeding it quotient, divisor and remainder reconstructs the dividend.
- The calculator top level uses it for the multiply key, with C=0, and for divide self-check.
- Control is a start/busy/done handshake driven by the calculator controller.

Parameters:
- WIDTH, 4: operand width of A, B and C. P is 2*WIDTH bits wide.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation. Sampled only in the IDLE state.
- A  in  WIDTH  multiplicand.
- B  in  WIDTH  multiplier.
- C  in  WIDTH  addend (remainder for the divide check; 0 for a plain multiply).
- busy  out  1  high while an operation is in progress (LOAD and ITER states).
- done  out  1  one-cycle pulse; P is updated in the same cycle.
- P  out  2*WIDTH  result register, held until the next done.
- zero  out  1  high when P == 0.

Behaviour:
- Reset (rst=1 at a clock edge, in any state including mid-operation):
  - state goes to IDLE; P=0, done=0, busy=0, zero=1; iteration counter cleared.
  - Any operation in flight is abandoned; no done is produced for it.
- States: IDLE, LOAD, ITER, DONE; binary encoded.
- IDLE:
  - start=1 → LOAD, and A, B, C are latched into internal registers.
  - Operand changes after this edge have no effect.
- LOAD (1 cycle):
  - acc ← zero-extended C; mcand ← zero-extended A; mplier ← B; cnt ← WIDTH.
  - Next state is ITER.
- ITER (exactly WIDTH cycles; no early exit when mplier reaches 0):
  - If mplier[0]=1 then acc ← acc + mcand.
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt - 1.
  - When cnt reaches 1 on the current cycle → DONE.
- DONE (1 cycle):
  - P ← acc; done=1 registered in this cycle; busy=0. Next state is IDLE.
- Latency: start sampled at edge t → done high in cycle t+WIDTH+2. With WIDTH=4, done is high in the 6th cycle after the start edge.
- Maximum throughput is one operation per WIDTH+3 cycles.
- Width and overflow:
  - acc and mcand are 2*WIDTH bits. The largest possible result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so no overflow can occur and there is no carry-out port.
- start handling:
  - start is ignored in LOAD, ITER and DONE. It is not queued; the controller must reassert it after done.
  - start held high continuously launches back-to-back operations, entering LOAD from each IDLE.
- P is unchanged in every cycle except DONE; old results stay visible during busy.
- zero is combinational from P.
- B=0 or A=0: the full WIDTH iterations still run, and P=C.
- Simultaneous rst and start: reset wins and no operation begins.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, ITER, DONE);
  - default WIDTH constant;
  - counter width localparam, $clog2(WIDTH+1).
- One sub-module, mul_acc_dp: acc/mcand/mplier registers, adder and counter, driven by load/step enables.
- mul_acc keeps the FSM and the output registers.

Test Plan:
- Reset, then start with A=13, B=11, C=0 → after 6 cycles done=1 for exactly one cycle, P=143, zero=0; busy high for the 5 cycles before done.
- Divide inverse: A=4, B=3, C=2 → P=14, done in the 6th cycle after the start edge.
- Extremes: A=15, B=15, C=15 → P=240. Then A=0, B=9, C=7 → P=7. Then A=0, B=0, C=0 → P=0 and zero=1.
- Start during busy:
  - First op A=5, B=6, C=1. Start pulses again 2 cycles later with A=2, B=2, C=0.
  - Expect a single done, with P=31.
  - A fresh start afterwards gives P=4.
- Reset during ITER: after a completed op leaves P=143, assert rst in the 3rd ITER cycle → next cycle P=0, busy=0, done=0, zero=1, with no done pulse. A subsequent op A=7, B=7, C=0 → P=49.
- Back-to-back with start held high: A=3, B=5, C=0 → done every 7 cycles, P=15 each time, P stable between pulses.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// Shared types and constants for the shift-and-add multiply-accumulate unit.
package mul_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/mul_acc_dp.sv
// Datapath: accumulator, shifting multiplicand/multiplier and iteration down-counter.
module mul_acc_dp
  import mul_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [WIDTH-1:0]   c_i,
  output logic [2*WIDTH-1:0] acc_nxt_o,
  output logic               last_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      acc_d    = {{WIDTH{1'b0}}, c_i};
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CNT_W'(WIDTH);
    end else if (step_i) begin
      // Sum cannot exceed 2^(2W) - 2^W, so the accumulator never wraps.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Exposed so the result register can capture the final iteration directly.
  assign acc_nxt_o = acc_d;
  assign last_o    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mul_acc.sv
// Multiply-accumulate P = A*B + C; states: IDLE wait start | LOAD seed datapath |
// ITER one shift-add per cycle | DONE P and done visible for one cycle.
module mul_acc
  import mul_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P,
  output logic               zero
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               done_q, done_d;

  logic               dp_load;
  logic               dp_step;
  logic               dp_last;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    p_d     = p_q;
    done_d  = 1'b0;
    dp_load = 1'b0;
    dp_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          a_d     = A;
          b_d     = B;
          c_d     = C;
        end
      end
      LOAD: begin
        dp_load = 1'b1;
        state_d = ITER;
      end
      ITER: begin
        dp_step = 1'b1;
        // P and done are registered together so both appear in the DONE cycle.
        if (dp_last) begin
          state_d = DONE;
          p_d     = acc_nxt;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  mul_acc_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk_i    (CLK),
    .rst_i    (rst),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .a_i      (a_q),
    .b_i      (b_q),
    .c_i      (c_q),
    .acc_nxt_o(acc_nxt),
    .last_o   (dp_last)
  );

  assign busy = (state_q == LOAD) || (state_q == ITER);
  assign done = done_q;
  assign P    = p_q;
  assign zero = (p_q == '0);

endmodule
